// File: rtl/axis_gen_pkg.sv
// Shared encodings for the AXI4-Stream pattern generator: FSM states and
// run-time pattern modes.
package axis_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    MODE_COUNT = 2'd0,
    MODE_CONST = 2'd1,
    MODE_WALK  = 2'd2,
    MODE_TAG   = 2'd3
  } mode_t;

endpackage

// File: rtl/axis_pattern_word.sv
// Combinational pattern function: maps (mode, seed, word/packet/beat index)
// to the TDATA word presented by the generator.
module axis_pattern_word
  import axis_gen_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16,
  parameter int ROT_W      = 5
) (
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] seed,
  input  logic [DATA_WIDTH-1:0] w,
  input  logic [ROT_W-1:0]      w_rot,
  input  logic [CNT_WIDTH-1:0]  p,
  input  logic [CNT_WIDTH-1:0]  b,
  output logic [DATA_WIDTH-1:0] word
);

  localparam int HALF = DATA_WIDTH / 2;

  logic [HALF-1:0] p_half;
  logic [HALF-1:0] b_half;

  // w_rot is w mod DATA_WIDTH, kept by the caller as a wrapping counter so no
  // divider is needed when DATA_WIDTH is not a power of two.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the block leaves it unassigned and a latch is never inferred.
    word   = '0;
    p_half = HALF'(p);
    b_half = HALF'(b);
    case (mode_t'(mode))
      MODE_COUNT: word = seed + w;
      MODE_CONST: word = seed;
      MODE_WALK:  word = (seed << w_rot) | (seed >> (DATA_WIDTH - int'(w_rot)));
      MODE_TAG:   word = {p_half, b_half};
      default:    word = '0;
    endcase
  end

endmodule

// File: rtl/axis_pattern_generator.sv
// Packetised AXI4-Stream traffic generator with four data patterns.
// Optional AXIS_PATTERN_GEN_STALL_STATS_EN adds a saturating stall_count output.
module axis_pattern_generator
  import axis_gen_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int PKT_LEN    = 16,
  parameter int NUM_PKTS   = 4,
  parameter int GAP_CYCLES = 0,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] seed,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  pkt_count
`ifdef AXIS_PATTERN_GEN_STALL_STATS_EN
  ,
  output logic [31:0]           stall_count
`endif
);

  localparam int ROT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

  localparam logic [ROT_W-1:0]     ROT_LAST  = ROT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] BEAT_LAST = CNT_WIDTH'(PKT_LEN - 1);
  localparam logic [CNT_WIDTH-1:0] PKT_GOAL  = CNT_WIDTH'(NUM_PKTS);
  localparam logic [GAP_W-1:0]     GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t state;
  state_t state_next;

  logic [1:0]            mode_q;
  logic [DATA_WIDTH-1:0] seed_q;
  logic [DATA_WIDTH-1:0] word_idx;
  logic [ROT_W-1:0]      rot_idx;
  logic [CNT_WIDTH-1:0]  beat_idx;
  logic [CNT_WIDTH-1:0]  pkt_cnt_q;
  logic [GAP_W-1:0]      gap_cnt;
  logic                  stop_pend;
  logic [DATA_WIDTH-1:0] tdata_q;

  logic                  xfer;
  logic                  beat_last;
  logic                  last_xfer;
  logic                  start_ok;
  logic                  run_end;
  logic [CNT_WIDTH-1:0]  pkt_count_inc;

  logic [1:0]            pat_mode;
  logic [DATA_WIDTH-1:0] pat_seed;
  logic [DATA_WIDTH-1:0] pat_w;
  logic [ROT_W-1:0]      pat_rot;
  logic [CNT_WIDTH-1:0]  pat_p;
  logic [CNT_WIDTH-1:0]  pat_b;
  logic [DATA_WIDTH-1:0] pat_word;

  assign m_axis_tvalid = (state == ST_SEND);
  assign m_axis_tlast  = m_axis_tvalid & beat_last;
  assign m_axis_tdata  = tdata_q;
  assign busy          = (state == ST_SEND) || (state == ST_GAP);
  assign done          = (state == ST_DONE);
  assign pkt_count     = pkt_cnt_q;

  assign xfer          = m_axis_tvalid & m_axis_tready;
  assign beat_last     = (beat_idx == BEAT_LAST);
  assign last_xfer     = xfer & beat_last;
  assign start_ok      = start & ((state == ST_IDLE) || (state == ST_DONE));
  assign pkt_count_inc = pkt_cnt_q + 1'b1;
  // A stop arriving together with the last-beat transfer still ends the run.
  assign run_end       = ((NUM_PKTS != 0) && (pkt_count_inc == PKT_GOAL)) || stop_pend || stop;

  // Indices of the word that follows a transfer; a start instead selects word 0
  // of the freshly presented mode and seed.
  always_comb begin
    pat_mode = mode_q;
    pat_seed = seed_q;
    pat_w    = word_idx + 1'b1;
    pat_rot  = (rot_idx == ROT_LAST) ? '0 : rot_idx + 1'b1;
    pat_p    = beat_last ? pkt_count_inc : pkt_cnt_q;
    pat_b    = beat_last ? '0 : beat_idx + 1'b1;
    if (start_ok) begin
      pat_mode = mode;
      pat_seed = seed;
      pat_w    = '0;
      pat_rot  = '0;
      pat_p    = '0;
      pat_b    = '0;
    end
  end

  axis_pattern_word #(
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH),
    .ROT_W      (ROT_W)
  ) u_word (
    .mode  (pat_mode),
    .seed  (pat_seed),
    .w     (pat_w),
    .w_rot (pat_rot),
    .p     (pat_p),
    .b     (pat_b),
    .word  (pat_word)
  );

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) state_next = ST_SEND;
      end
      ST_SEND: begin
        if (last_xfer) begin
          if (run_end)             state_next = ST_DONE;
          else if (GAP_CYCLES > 0) state_next = ST_GAP;
          else                     state_next = ST_SEND;
        end
      end
      ST_GAP: begin
        if (stop || stop_pend)        state_next = ST_DONE;
        else if (gap_cnt == GAP_LAST) state_next = ST_SEND;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order within or across blocks.
  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mode_q    <= '0;
      seed_q    <= '0;
      word_idx  <= '0;
      rot_idx   <= '0;
      beat_idx  <= '0;
      pkt_cnt_q <= '0;
      gap_cnt   <= '0;
      stop_pend <= 1'b0;
      tdata_q   <= '0;
    end else if (start_ok) begin
      mode_q    <= mode;
      seed_q    <= seed;
      word_idx  <= '0;
      rot_idx   <= '0;
      beat_idx  <= '0;
      pkt_cnt_q <= '0;
      gap_cnt   <= '0;
      stop_pend <= 1'b0;
      tdata_q   <= pat_word;
    end else begin
      if (stop && busy) stop_pend <= 1'b1;
      if (xfer) begin
        word_idx  <= pat_w;
        rot_idx   <= pat_rot;
        beat_idx  <= pat_b;
        pkt_cnt_q <= pat_p;
        tdata_q   <= pat_word;
      end
      gap_cnt <= (state == ST_GAP) ? gap_cnt + 1'b1 : '0;
    end
  end

`ifdef AXIS_PATTERN_GEN_STALL_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset || start_ok)
      stall_count <= '0;
    else if (m_axis_tvalid && !m_axis_tready && (stall_count != '1))
      stall_count <= stall_count + 1'b1;
  end
`endif

endmodule

// File: tb/tb_axis_pattern_generator.sv
// Scoreboard bench for axis_pattern_generator: one default instance and one
// with NUM_PKTS=0, GAP_CYCLES=3; monitors pop expected beats on every transfer.
module tb_axis_pattern_generator;
  import axis_gen_pkg::*;

  localparam int DW = 32;
  localparam int CW = 16;

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          a_reset, a_start, a_stop, a_tready, a_tvalid, a_tlast, a_busy, a_done;
  logic [1:0]    a_mode;
  logic [DW-1:0] a_seed, a_tdata;
  logic [CW-1:0] a_pkt_count;
  logic          b_reset, b_start, b_stop, b_tready, b_tvalid, b_tlast, b_busy, b_done;
  logic [1:0]    b_mode;
  logic [DW-1:0] b_seed, b_tdata;
  logic [CW-1:0] b_pkt_count;
`ifdef AXIS_PATTERN_GEN_STALL_STATS_EN
  logic [31:0]   a_stall_count, b_stall_count;
`endif

  axis_pattern_generator dut_a (
    .clk(clk), .reset(a_reset), .start(a_start), .stop(a_stop), .mode(a_mode), .seed(a_seed),
    .m_axis_tdata(a_tdata), .m_axis_tvalid(a_tvalid), .m_axis_tlast(a_tlast),
    .m_axis_tready(a_tready), .busy(a_busy), .done(a_done), .pkt_count(a_pkt_count)
`ifdef AXIS_PATTERN_GEN_STALL_STATS_EN
    , .stall_count(a_stall_count)
`endif
  );

  axis_pattern_generator #(.NUM_PKTS(0), .GAP_CYCLES(3)) dut_b (
    .clk(clk), .reset(b_reset), .start(b_start), .stop(b_stop), .mode(b_mode), .seed(b_seed),
    .m_axis_tdata(b_tdata), .m_axis_tvalid(b_tvalid), .m_axis_tlast(b_tlast),
    .m_axis_tready(b_tready), .busy(b_busy), .done(b_done), .pkt_count(b_pkt_count)
`ifdef AXIS_PATTERN_GEN_STALL_STATS_EN
    , .stall_count(b_stall_count)
`endif
  );

  beat_t a_q[$];
  beat_t b_q[$];
  int    checks = 0;
  int    errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor A: scoreboard pop on transfer, plus hold-stable check after a stall.
  int    a_xfers = 0;
  logic  a_prev_stall = 1'b0;
  beat_t a_prev, a_exp;
  always @(negedge clk) begin
    if (a_prev_stall) begin
      check("a_hold_valid", 64'(a_tvalid), 64'd1);
      check("a_hold_beat", 64'({a_tlast, a_tdata}), 64'(a_prev));
    end
    if (a_tvalid && a_tready) begin
      a_xfers++;
      if (a_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected_beat actual=%0h required=none", a_tdata);
      end else begin
        a_exp = a_q.pop_front();
        check("a_beat", 64'({a_tlast, a_tdata}), 64'(a_exp));
      end
    end
    a_prev_stall = a_tvalid && !a_tready && a_reset;
    a_prev       = '{last: a_tlast, data: a_tdata};
  end

  // Monitor B: scoreboard pop on transfer, plus idle-gap length between packets.
  int    b_gap_run = 0;
  bit    b_gap_active = 1'b0;
  beat_t b_exp;
  always @(negedge clk) begin
    if (b_tvalid) begin
      if (b_gap_active) check("b_gap_len", 64'(b_gap_run), 64'd3);
      b_gap_active = 1'b0;
    end else if (b_gap_active) begin
      if (b_busy) b_gap_run++;
      else        b_gap_active = 1'b0;
    end
    if (b_tvalid && b_tready) begin
      if (b_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected_beat actual=%0h required=none", b_tdata);
      end else begin
        b_exp = b_q.pop_front();
        check("b_beat", 64'({b_tlast, b_tdata}), 64'(b_exp));
      end
      if (b_tlast) begin
        b_gap_active = 1'b1;
        b_gap_run    = 0;
      end
    end
  end

  task automatic start_a(input logic [1:0] m, input logic [DW-1:0] s);
    @(posedge clk); #1;
    a_start = 1'b1; a_mode = m; a_seed = s;
    @(posedge clk); #1;
    a_start = 1'b0;
  endtask

  task automatic start_b(input logic [1:0] m, input logic [DW-1:0] s);
    @(posedge clk); #1;
    b_start = 1'b1; b_mode = m; b_seed = s;
    @(posedge clk); #1;
    b_start = 1'b0;
  endtask

  task automatic wait_done(input bit which_b, input int max_cycles, input string name);
    int n = 0;
    while (!(which_b ? b_done : a_done) && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(which_b ? b_done : a_done), 64'd1);
  endtask

  bit tog_en = 1'b0;
  bit found;

  initial begin
    a_reset = 0; a_start = 0; a_stop = 0; a_tready = 1; a_mode = 0; a_seed = 0;
    b_reset = 0; b_start = 0; b_stop = 0; b_tready = 1; b_mode = 0; b_seed = 0;
    repeat (3) @(posedge clk);
    #1 a_reset = 1; b_reset = 1;
    @(negedge clk);
    check("rst_tvalid", 64'(a_tvalid), 64'd0);
    check("rst_tlast", 64'(a_tlast), 64'd0);
    check("rst_tdata", 64'(a_tdata), 64'd0);
    check("rst_busy", 64'(a_busy), 64'd0);
    check("rst_done", 64'(a_done), 64'd0);
    check("rst_pkt_count", 64'(a_pkt_count), 64'd0);

    // Counter mode, full rate: 0x100..0x13F, tlast every 16th beat.
    for (int i = 0; i < 64; i++) a_q.push_back('{last: (i % 16) == 15, data: DW'(32'h100 + i)});
    a_xfers = 0;
    start_a(MODE_COUNT, 32'h100);
    wait_done(1'b0, 400, "t1_done");
    check("t1_pkt_count", 64'(a_pkt_count), 64'd4);
    check("t1_xfers", 64'(a_xfers), 64'd64);
    check("t1_queue_empty", 64'(a_q.size()), 64'd0);
    check("t1_busy", 64'(a_busy), 64'd0);
    check("t1_tvalid", 64'(a_tvalid), 64'd0);

    // Walking one under alternating backpressure.
    for (int i = 0; i < 64; i++) a_q.push_back('{last: (i % 16) == 15, data: DW'(32'h1) << (i % 32)});
    a_xfers = 0;
    start_a(MODE_WALK, 32'h1);
    tog_en = 1'b1;
    fork
      while (tog_en) begin
        @(posedge clk); #1;
        a_tready = ~a_tready;
      end
    join_none
    wait_done(1'b0, 600, "t2_done");
    tog_en = 1'b0;
    @(posedge clk); #2;
    a_tready = 1'b1;
    check("t2_xfers", 64'(a_xfers), 64'd64);
    check("t2_queue_empty", 64'(a_q.size()), 64'd0);

    // Start while busy is ignored; first word held through five stall cycles.
    a_tready = 1'b0;
    for (int i = 0; i < 64; i++) a_q.push_back('{last: (i % 16) == 15, data: DW'(32'h500 + i)});
    start_a(MODE_COUNT, 32'h500);
    @(posedge clk); #1;
    a_start = 1'b1; a_mode = MODE_CONST; a_seed = 32'hdead_beef;
    @(posedge clk); #1;
    a_start = 1'b0;
    check("t3_busy", 64'(a_busy), 64'd1);
    check("t3_held_word", 64'(a_tdata), 64'h500);
    repeat (3) @(posedge clk);
    #1 a_tready = 1'b1;
    wait_done(1'b0, 400, "t3_done");
    check("t3_pkt_count", 64'(a_pkt_count), 64'd4);
    check("t3_queue_empty", 64'(a_q.size()), 64'd0);
`ifdef AXIS_PATTERN_GEN_STALL_STATS_EN
    check("t3_stall_count", 64'(a_stall_count), 64'd5);
`endif

    // Reset on beat 9 of packet 1 (word 25), then a clean restart.
    for (int i = 0; i < 26; i++) a_q.push_back('{last: (i % 16) == 15, data: DW'(32'h40 + i)});
    start_a(MODE_COUNT, 32'h40);
    found = 1'b0;
    for (int n = 0; n < 100 && !found; n++) begin
      if (a_tvalid && a_tdata == 32'h59) found = 1'b1;
      else @(negedge clk);
    end
    check("t4_reach_beat", 64'(found), 64'd1);
    a_reset = 1'b0;
    @(negedge clk);
    check("t4_rst_tvalid", 64'(a_tvalid), 64'd0);
    check("t4_rst_busy", 64'(a_busy), 64'd0);
    check("t4_rst_pkt_count", 64'(a_pkt_count), 64'd0);
    check("t4_rst_tdata", 64'(a_tdata), 64'd0);
    check("t4_queue_empty", 64'(a_q.size()), 64'd0);
    @(posedge clk); #1;
    a_reset = 1'b1;
    for (int i = 0; i < 64; i++) a_q.push_back('{last: (i % 16) == 15, data: DW'(32'h40 + i)});
    start_a(MODE_COUNT, 32'h40);
    wait_done(1'b0, 400, "t4_done");
    check("t4_restart_queue_empty", 64'(a_q.size()), 64'd0);

    // Tagged mode with 3-cycle gaps; stop on beat 7 of packet 2.
    for (int i = 0; i < 48; i++)
      b_q.push_back('{last: (i % 16) == 15, data: {16'(i / 16), 16'(i % 16)}});
    start_b(MODE_TAG, 32'h0);
    found = 1'b0;
    for (int n = 0; n < 300 && !found; n++) begin
      if (b_tvalid && b_tdata == 32'h0002_0007) found = 1'b1;
      else @(negedge clk);
    end
    check("t5_reach_beat", 64'(found), 64'd1);
    b_stop = 1'b1;
    @(posedge clk); #1;
    b_stop = 1'b0;
    wait_done(1'b1, 200, "t5_done");
    check("t5_pkt_count", 64'(b_pkt_count), 64'd3);
    check("t5_queue_empty", 64'(b_q.size()), 64'd0);

    // Stop during the inter-packet gap ends the run after one packet.
    for (int i = 0; i < 16; i++) b_q.push_back('{last: i == 15, data: DW'(32'h10 + i)});
    start_b(MODE_COUNT, 32'h10);
    found = 1'b0;
    for (int n = 0; n < 100 && !found; n++) begin
      if (b_tvalid && b_tlast) found = 1'b1;
      else @(negedge clk);
    end
    check("t6_reach_last", 64'(found), 64'd1);
    @(posedge clk); #1;
    b_stop = 1'b1;
    @(posedge clk); #1;
    b_stop = 1'b0;
    wait_done(1'b1, 20, "t6_done");
    check("t6_pkt_count", 64'(b_pkt_count), 64'd1);
    check("t6_queue_empty", 64'(b_q.size()), 64'd0);
    check("t6_tvalid", 64'(b_tvalid), 64'd0);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
